// File: rtl/hazard_control_if.sv
// Decode-side hazard interface: the decode stage drives operand/destination info,
// the hazard controller returns stall/squash and the stall-cycle counter.
interface hazard_control_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       a0;
  logic [4:0]       a1;
  logic             use_a0;
  logic             use_a1;
  logic [4:0]       a2_hazard;
  logic             dst_wr_en;
  logic             jmp_taken;
  logic             stall;
  logic             squash;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output a0, a1, use_a0, use_a1, a2_hazard, dst_wr_en, jmp_taken,
    input  stall, squash, stall_count
  );

  modport slave (
    input  a0, a1, use_a0, use_a1, a2_hazard, dst_wr_en, jmp_taken,
    output stall, squash, stall_count
  );
endinterface

// File: rtl/hazard_control.sv
// Pipeline hazard/flush controller: shift-register scoreboard of in-flight
// destinations, data-hazard stall, and two-slot squash after a taken jump.
module hazard_control #(
  parameter int DEPTH = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  hazard_control_if.slave  bus
);

  logic [DEPTH-1:0] r_sb_vld;
  logic [4:0]       r_sb_reg [DEPTH];
  logic             r_flush_pending;
  logic [CNT_W-1:0] r_stall_cnt;

  logic             w_match0;
  logic             w_match1;
  logic             w_hazard;
  logic             w_squash;
  logic             w_stall;
  logic             w_insert;

  // Source-operand match against every valid in-flight destination, including writeback slot.
  always_comb begin
    w_match0 = 1'b0;
    w_match1 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_sb_vld[i] && (r_sb_reg[i] == bus.a0)) begin
        w_match0 = 1'b1;
      end else begin
        w_match0 = w_match0;
      end
      if (r_sb_vld[i] && (r_sb_reg[i] == bus.a1)) begin
        w_match1 = 1'b1;
      end else begin
        w_match1 = w_match1;
      end
    end
    w_match0 = w_match0 & bus.use_a0 & (bus.a0 != 5'd0);
    w_match1 = w_match1 & bus.use_a1 & (bus.a1 != 5'd0);
  end

  // Jump flush dominates the data stall; reset forces both controls low.
  always_comb begin
    w_hazard = w_match0 | w_match1;
    if (!rst) begin
      w_squash = 1'b0;
      w_stall  = 1'b0;
    end else begin
      w_squash = bus.jmp_taken | r_flush_pending | w_hazard;
      w_stall  = w_hazard & ~bus.jmp_taken & ~r_flush_pending;
    end
    w_insert = bus.dst_wr_en & ~w_squash & (bus.a2_hazard != 5'd0);
  end

  assign bus.stall       = w_stall;
  assign bus.squash      = w_squash;
  assign bus.stall_count = r_stall_cnt;

  // Scoreboard shifts every cycle so the back end keeps draining during a stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sb_vld <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_sb_reg[i] <= 5'd0;
      end
    end else begin
      r_sb_vld[0] <= w_insert;
      r_sb_reg[0] <= bus.a2_hazard;
      for (int i = 1; i < DEPTH; i++) begin
        r_sb_vld[i] <= r_sb_vld[i-1];
        r_sb_reg[i] <= r_sb_reg[i-1];
      end
    end
  end

  // Flush-pending flag covers the instruction fetched right after the jump cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_flush_pending <= 1'b0;
    end else begin
      r_flush_pending <= bus.jmp_taken;
    end
  end

  // Saturating count of data-hazard stall cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= {CNT_W{1'b0}};
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

endmodule

// File: tb/tb_hazard_control.sv
// Randomized + directed bench for hazard_control with a queue-based scoreboard
// and a list-of-in-flight-writes reference model.
module tb_hazard_control;
  localparam int DEPTH = 3;

  logic clk;
  logic rst;

  hazard_control_if #(.CNT_W(16)) bus  ();
  hazard_control_if #(.CNT_W(4))  bus4 ();

  hazard_control #(.DEPTH(DEPTH), .CNT_W(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  hazard_control #(.DEPTH(DEPTH), .CNT_W(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  assign bus4.a0        = bus.a0;
  assign bus4.a1        = bus.a1;
  assign bus4.use_a0    = bus.use_a0;
  assign bus4.use_a1    = bus.use_a1;
  assign bus4.a2_hazard = bus.a2_hazard;
  assign bus4.dst_wr_en = bus.dst_wr_en;
  assign bus4.jmp_taken = bus.jmp_taken;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        sq;
    logic [15:0] c16;
    logic [3:0]  c4;
  } exp_t;

  typedef struct {
    logic [4:0] r;
    int         age;
  } wr_t;

  exp_t exp_q[$];
  wr_t  inflight[$];
  logic        m_fp;
  logic [15:0] m_cnt16;
  logic [3:0]  m_cnt4;

  int n_checks = 0;
  int n_fail   = 0;

  // Apply one decode cycle's inputs and push what the outputs must be in that cycle.
  task automatic drive(input logic [4:0] a0v, input logic [4:0] a1v, input logic u0,
                       input logic u1, input logic [4:0] a2v, input logic we,
                       input logic jmp, input logic rstv);
    exp_t e;
    wr_t  nq[$];
    logic hz;
    @(negedge clk);
    bus.a0 = a0v; bus.a1 = a1v; bus.use_a0 = u0; bus.use_a1 = u1;
    bus.a2_hazard = a2v; bus.dst_wr_en = we; bus.jmp_taken = jmp;
    rst = rstv;
    if (!rstv) begin
      inflight.delete();
      m_fp = 1'b0; m_cnt16 = 16'd0; m_cnt4 = 4'd0;
      e = '{st: 1'b0, sq: 1'b0, c16: 16'd0, c4: 4'd0};
    end else begin
      hz = 1'b0;
      foreach (inflight[i]) begin
        if ((u0 && a0v != 5'd0 && inflight[i].r == a0v) ||
            (u1 && a1v != 5'd0 && inflight[i].r == a1v)) hz = 1'b1;
      end
      e.sq  = jmp | m_fp | hz;
      e.st  = hz & ~jmp & ~m_fp;
      e.c16 = m_cnt16;
      e.c4  = m_cnt4;
      foreach (inflight[i]) begin
        if (inflight[i].age + 1 < DEPTH) nq.push_back('{r: inflight[i].r, age: inflight[i].age + 1});
      end
      if (we && !e.sq && a2v != 5'd0) nq.push_back('{r: a2v, age: 0});
      inflight = nq;
      m_fp = jmp;
      if (e.st) begin
        if (m_cnt16 != 16'hFFFF) m_cnt16 = m_cnt16 + 16'd1;
        if (m_cnt4 != 4'hF) m_cnt4 = m_cnt4 + 4'd1;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: pop the expected response for each presented cycle and compare.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_checks += 4;
        if (bus.stall !== e.st) begin
          n_fail++;
          $display("FAIL stall t=%0t got=%b exp=%b", $time, bus.stall, e.st);
        end
        if (bus.squash !== e.sq) begin
          n_fail++;
          $display("FAIL squash t=%0t got=%b exp=%b", $time, bus.squash, e.sq);
        end
        if (bus.stall_count !== e.c16) begin
          n_fail++;
          $display("FAIL stall_count t=%0t got=%0d exp=%0d", $time, bus.stall_count, e.c16);
        end
        if (bus4.stall_count !== e.c4) begin
          n_fail++;
          $display("FAIL stall_count_w4 t=%0t got=%0d exp=%0d", $time, bus4.stall_count, e.c4);
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    bus.a0 = 5'd0; bus.a1 = 5'd0; bus.use_a0 = 1'b0; bus.use_a1 = 1'b0;
    bus.a2_hazard = 5'd0; bus.dst_wr_en = 1'b0; bus.jmp_taken = 1'b0;
    m_fp = 1'b0; m_cnt16 = 16'd0; m_cnt4 = 4'd0;
    repeat (3) drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

    // Reset release, reader of x5 with nothing in flight
    drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);

    // Producer x5 then dependent reader held through its stall
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1);
    repeat (4) drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    idle();

    // Producer x7, three independent, reader of x7; then x0 producer/reader
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1);
    repeat (3) drive(5'd1, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1);
    drive(5'd7, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
    drive(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    repeat (3) idle();

    // Jump during hazard on a1=x9, wrong-path write of x9, later reader of x9
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1);
    drive(5'd0, 5'd9, 1'b0, 1'b1, 5'd9, 1'b1, 1'b1, 1'b1);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1);
    idle();
    repeat (3) drive(5'd0, 5'd9, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    // Back-to-back jumps
    repeat (3) drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b1);
    repeat (2) idle();

    // Reset mid-stall on x3
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1);
    drive(5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    drive(5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) drive(5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);

    // Saturate the 4-bit counter: 7 producer/reader pairs = 21 stall cycles
    repeat (7) begin
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b1);
      repeat (4) drive(5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    end

    // Randomized traffic over a small register range to provoke hits
    for (int k = 0; k < 600; k++) begin
      drive(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom),
            1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 99) != 0));
    end

    repeat (3) @(negedge clk);
    #4;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
